// File: rtl/divi_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Holds the FSM state encoding and the bit-counter width function.
// No logic of its own.
package divi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Counter must hold DIVIDEND_W-1; clog2(w) bits always suffice for w-1.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/divi_step.sv
// One combinational restoring-division step.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: rem_i partial remainder, dnd_bit_i next dividend bit, dvs_i divisor
//        magnitude; rem_o next partial remainder, q_bit_o quotient bit.
module divi_step
  import divi_pkg::*;
#(
  parameter int DIVISOR_W = 16
) (
  input  logic [DIVISOR_W-1:0] rem_i,
  input  logic                 dnd_bit_i,
  input  logic [DIVISOR_W-1:0] dvs_i,
  output logic [DIVISOR_W-1:0] rem_o,
  output logic                 q_bit_o
);

  logic [DIVISOR_W:0] shifted;

  always_comb begin
    shifted = {rem_i, dnd_bit_i};
    // Trial subtraction is non-negative exactly when shifted >= divisor.
    q_bit_o = (shifted >= {1'b0, dvs_i});
    // When the subtraction is kept the true result is < divisor, so the
    // low DIVISOR_W bits of the difference are exact.
    rem_o   = q_bit_o ? (shifted[DIVISOR_W-1:0] - dvs_i) : shifted[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/divi_seq.sv
// Sequential restoring divider, one quotient bit per clock, optional signed mode.
// Latency: DIVIDEND_W+1 cycles from accept to out_valid; zero divisor goes straight to DONE.
// Backpressure: single operation in flight; in_ready low until the result is taken by out_ready.
// Ports: sys_clk/sys_rst (async, active-high); in_valid/in_ready/dividend/divisor operand side;
//        out_valid/out_ready/quotient/remainder/div_by_zero result side.
module divi_seq
  import divi_pkg::*;
#(
  parameter int DIVIDEND_W = 25,
  parameter int DIVISOR_W  = 16,
  parameter int SIGNED     = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CW = cnt_w(DIVIDEND_W);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  // Dividend magnitude; quotient bits shift in from the bottom as the
  // dividend bits shift out of the top, so it ends up holding the quotient.
  logic [DIVIDEND_W-1:0] dnd_q, dnd_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic                  dnd_neg_q, dnd_neg_d;
  logic                  dvs_neg_q, dvs_neg_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rmd_q, rmd_d;
  logic                  dbz_q, dbz_d;
  logic                  ov_q, ov_d;

  logic                  in_dnd_neg, in_dvs_neg;
  logic [DIVIDEND_W-1:0] in_dnd_mag;
  logic [DIVISOR_W-1:0]  in_dvs_mag;
  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_q;

  // Operand conditioning: sign bits only matter in signed mode. The
  // magnitude of the most-negative value still fits as an unsigned number.
  always_comb begin
    in_dnd_neg = (SIGNED != 0) && dividend[DIVIDEND_W-1];
    in_dvs_neg = (SIGNED != 0) && divisor[DIVISOR_W-1];
    in_dnd_mag = in_dnd_neg ? (~dividend + 1'b1) : dividend;
    in_dvs_mag = in_dvs_neg ? (~divisor + 1'b1) : divisor;
  end

  divi_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_i     (rem_q),
    .dnd_bit_i (dnd_q[DIVIDEND_W-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dnd_d     = dnd_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    dnd_neg_d = dnd_neg_q;
    dvs_neg_d = dvs_neg_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    dbz_d     = dbz_q;
    ov_d      = ov_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dnd_d     = in_dnd_mag;
          dvs_d     = in_dvs_mag;
          dnd_neg_d = in_dnd_neg;
          dvs_neg_d = in_dvs_neg;
          rem_d     = '0;
          cnt_d     = CW'(DIVIDEND_W - 1);
          dbz_d     = (divisor == '0);
          if (divisor == '0) begin
            // Zero divisor skips the iteration and presents a fixed result.
            quo_d   = '1;
            rmd_d   = in_dnd_mag[DIVISOR_W-1:0];
            ov_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dnd_d = {dnd_q[DIVIDEND_W-2:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // Truncating division: quotient sign from both operands, remainder
        // follows the dividend. Most-negative / -1 wraps naturally.
        quo_d   = (dnd_neg_q ^ dvs_neg_q) ? (~dnd_q + 1'b1) : dnd_q;
        rmd_d   = dnd_neg_q ? (~rem_q + 1'b1) : rem_q;
        ov_d    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dnd_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      dnd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      quo_q     <= '0;
      rmd_q     <= '0;
      dbz_q     <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dnd_q     <= dnd_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      dnd_neg_q <= dnd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      quo_q     <= quo_d;
      rmd_q     <= rmd_d;
      dbz_q     <= dbz_d;
      ov_q      <= ov_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = ov_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divi_seq.sv
// Bench for divi_seq: one unsigned and one signed instance driven with the
// same operands, each checked every cycle against an arithmetic model.
module tb_divi_seq;

  localparam int DW = 25;
  localparam int VW = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;

  logic          u_in_ready, u_out_valid, u_dbz;
  logic [DW-1:0] u_quo;
  logic [VW-1:0] u_rem;
  logic          s_in_ready, s_out_valid, s_dbz;
  logic [DW-1:0] s_quo;
  logic [VW-1:0] s_rem;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 sys_clk = ~sys_clk;

  divi_seq #(.DIVIDEND_W(DW), .DIVISOR_W(VW), .SIGNED(0)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid), .in_ready(u_in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(u_out_valid), .out_ready(out_ready),
    .quotient(u_quo), .remainder(u_rem), .div_by_zero(u_dbz)
  );

  divi_seq #(.DIVIDEND_W(DW), .DIVISOR_W(VW), .SIGNED(1)) s_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(s_out_valid), .out_ready(out_ready),
    .quotient(s_quo), .remainder(s_rem), .div_by_zero(s_dbz)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: truncating division on 64-bit integers.
  function automatic logic [DW-1:0] mq(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit sgn);
    longint na, nb, lq;
    if (b == '0) return '1;
    na = sgn ? longint'($signed(a)) : longint'(a);
    nb = sgn ? longint'($signed(b)) : longint'(b);
    lq = na / nb;
    return lq[DW-1:0];
  endfunction

  function automatic logic [VW-1:0] mr(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit sgn);
    longint na, nb, lr;
    if (b == '0) return a[VW-1:0];
    na = sgn ? longint'($signed(a)) : longint'(a);
    nb = sgn ? longint'($signed(b)) : longint'(b);
    lr = na % nb;
    return lr[VW-1:0];
  endfunction

  // Transaction-level model: busy from accept until the result is taken,
  // result appears DW+1 edges after accept (immediately for a zero divisor).
  bit            m_busy = 1'b0, m_valid = 1'b0, m_dbz = 1'b0;
  int            m_wait = 0;
  logic [DW-1:0] pu_q, ps_q, eu_q, es_q;
  logic [VW-1:0] pu_r, ps_r, eu_r, es_r;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_dbz   <= 1'b0;
      m_wait  <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_dbz  <= (divisor == '0);
        pu_q   <= mq(dividend, divisor, 1'b0);
        pu_r   <= mr(dividend, divisor, 1'b0);
        ps_q   <= mq(dividend, divisor, 1'b1);
        ps_r   <= mr(dividend, divisor, 1'b1);
        if (divisor == '0) begin
          m_valid <= 1'b1;
          eu_q    <= mq(dividend, divisor, 1'b0);
          eu_r    <= mr(dividend, divisor, 1'b0);
          es_q    <= mq(dividend, divisor, 1'b1);
          es_r    <= mr(dividend, divisor, 1'b1);
        end else begin
          m_wait <= DW + 1;
        end
      end
    end else if (!m_valid) begin
      if (m_wait == 1) begin
        m_valid <= 1'b1;
        eu_q    <= pu_q;
        eu_r    <= pu_r;
        es_q    <= ps_q;
        es_r    <= ps_r;
      end
      m_wait <= m_wait - 1;
    end else if (out_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("u_in_ready", u_in_ready, !m_busy);
      chk("s_in_ready", s_in_ready, !m_busy);
      chk("u_out_valid", u_out_valid, m_valid);
      chk("s_out_valid", s_out_valid, m_valid);
      chk("u_dbz", u_dbz, m_dbz);
      chk("s_dbz", s_dbz, m_dbz);
      if (m_valid) begin
        chk("u_quotient", u_quo, eu_q);
        chk("u_remainder", u_rem, eu_r);
        chk("s_quotient", s_quo, es_q);
        chk("s_remainder", s_rem, es_r);
      end
    end
  end

  // Called at a negedge while idle; returns at the negedge after the accept edge.
  task automatic send(input logic [DW-1:0] a, input logic [VW-1:0] b);
    chk("send_in_ready", u_in_ready, 1'b1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    in_valid = 1'b0;
  endtask

  // Counts clock edges after the accept edge until out_valid is observed.
  task automatic wait_res(output int lat);
    lat = 0;
    while (u_out_valid !== 1'b1 && lat < 100) begin
      @(posedge sys_clk);
      lat++;
      @(negedge sys_clk);
    end
    if (lat >= 100) chk("result_timeout", u_out_valid, 1'b1);
  endtask

  int lat;

  initial begin
    // Hand-computed values pin the model arithmetic.
    chk("model_u_120_10", mq(25'd120, 16'd10, 1'b0), 25'd12);
    chk("model_s_m7_2_q", mq(25'h1FFFFF9, 16'd2, 1'b1), 25'h1FFFFFD);
    chk("model_s_m7_2_r", mr(25'h1FFFFF9, 16'd2, 1'b1), 16'hFFFF);
    chk("model_s_ovf_q", mq(25'h1000000, 16'hFFFF, 1'b1), 25'h1000000);

    @(posedge sys_clk);
    chk_en = 1'b1;
    @(negedge sys_clk);
    chk("rst_in_ready", u_in_ready, 1'b1);
    chk("rst_out_valid", u_out_valid, 1'b0);
    chk("rst_quotient", u_quo, 25'd0);
    chk("rst_remainder", s_rem, 16'd0);
    chk("rst_dbz", s_dbz, 1'b0);
    in_valid = 1'b1;
    divisor  = 16'd3;
    @(negedge sys_clk);
    chk("rst_no_accept", u_in_ready, 1'b1);
    in_valid = 1'b0;
    sys_rst  = 1'b0;
    @(negedge sys_clk);

    send(25'd120, 16'd10);
    wait_res(lat);
    chk("lat_120_10", lat, DW + 1);
    chk("u_q_120_10", u_quo, 25'd12);
    chk("u_r_120_10", u_rem, 16'd0);
    chk("u_dbz_120_10", u_dbz, 1'b0);
    @(negedge sys_clk);

    send(25'd33554431, 16'd65535);
    wait_res(lat);
    chk("u_q_max", u_quo, 25'd512);
    chk("u_r_max", u_rem, 16'd511);
    @(negedge sys_clk);

    send(25'h1FFFFF9, 16'd2);
    wait_res(lat);
    chk("s_q_m7_2", s_quo, 25'h1FFFFFD);
    chk("s_r_m7_2", s_rem, 16'hFFFF);
    @(negedge sys_clk);

    send(25'd7, 16'hFFFE);
    wait_res(lat);
    chk("s_q_7_m2", s_quo, 25'h1FFFFFD);
    chk("s_r_7_m2", s_rem, 16'd1);
    @(negedge sys_clk);

    send(25'h1000000, 16'hFFFF);
    wait_res(lat);
    chk("s_q_ovf", s_quo, 25'h1000000);
    chk("s_r_ovf", s_rem, 16'd0);
    chk("s_dbz_ovf", s_dbz, 1'b0);
    @(negedge sys_clk);

    // Zero divisor: result is already visible at the first sample after accept.
    send(25'd100, 16'd0);
    wait_res(lat);
    chk("lat_div0", lat, 0);
    chk("u_q_div0", u_quo, 25'h1FFFFFF);
    chk("u_r_div0", u_rem, 16'd100);
    chk("u_dbz_div0", u_dbz, 1'b1);
    chk("s_dbz_div0", s_dbz, 1'b1);
    @(negedge sys_clk);
    send(25'd120, 16'd10);
    chk("dbz_cleared", u_dbz, 1'b0);
    wait_res(lat);
    @(negedge sys_clk);

    // Back-pressure: hold the result for 10 cycles, poke in_valid meanwhile.
    out_ready = 1'b0;
    send(25'd120, 16'd10);
    wait_res(lat);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        dividend = 25'd5;
        divisor  = 16'd1;
        in_valid = 1'b1;
      end
      if (i == 5) in_valid = 1'b0;
      @(negedge sys_clk);
      chk("bp_valid", u_out_valid, 1'b1);
      chk("bp_in_ready", u_in_ready, 1'b0);
      chk("bp_q", u_quo, 25'd12);
      chk("bp_r", u_rem, 16'd0);
    end
    out_ready = 1'b1;
    @(negedge sys_clk);
    chk("bp_released", u_out_valid, 1'b0);
    chk("bp_idle", u_in_ready, 1'b1);

    // Asynchronous reset during CALC.
    send(25'd1000, 16'd3);
    repeat (4) @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    chk("arst_out_valid", u_out_valid, 1'b0);
    chk("arst_in_ready", s_in_ready, 1'b1);
    chk("arst_q", u_quo, 25'd0);
    chk("arst_r", s_rem, 16'd0);
    chk("arst_dbz", u_dbz, 1'b0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (30) @(negedge sys_clk);
    send(25'd50, 16'd7);
    wait_res(lat);
    chk("lat_after_rst", lat, DW + 1);
    chk("u_q_50_7", u_quo, 25'd7);
    chk("u_r_50_7", u_rem, 16'd1);
    @(negedge sys_clk);

    // Random traffic with random gaps and stalls.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       dividend = 25'h1000000;
        1:       dividend = 25'h1FFFFFF;
        2:       dividend = 25'($urandom_range(0, 300));
        default: dividend = 25'($urandom());
      endcase
      case ($urandom_range(0, 6))
        0:       divisor = 16'd0;
        1:       divisor = 16'hFFFF;
        2:       divisor = 16'h8000;
        3:       divisor = 16'($urandom_range(1, 20));
        default: divisor = 16'($urandom());
      endcase
      if (divisor == '0) dividend[DW-1] = 1'b0;
      @(negedge sys_clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && !u_in_ready; c++) @(negedge sys_clk);
    chk("drain_idle", u_in_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/divi_seq.md
# divi_seq

Parametrised sequential restoring divider with valid/ready handshakes. It is the next-generation replacement for the fixed-width divider core used in the `divi_top` path. It adds a signed mode, a divide-by-zero flag and output back-pressure. It sits between an operand producer and a result consumer and computes one quotient bit per clock.

## Interface
- `DIVIDEND_W`, default 25: dividend and quotient width; must be ≥ 2.
- `DIVISOR_W`, default 16: divisor and remainder width; must be ≥ 2 and ≤ `DIVIDEND_W`.
- `SIGNED`, default 0: 0 = unsigned operands, 1 = two's-complement operands.
- `sys_clk` in 1: single clock; all logic is on the rising edge.
- `sys_rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept operands; `in_ready` = (state == IDLE).
- `dividend` in `DIVIDEND_W`: dividend.
- `divisor` in `DIVISOR_W`: divisor.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `quotient` out `DIVIDEND_W`: quotient.
- `remainder` out `DIVISOR_W`: remainder.
- `div_by_zero` out 1: the current result came from a zero divisor.

## Operation
- States and transitions:
  - IDLE: on accept (`in_valid & in_ready`), go to CALC, or to DONE if `divisor` == 0.
  - CALC: runs for exactly `DIVIDEND_W` cycles, then goes to FIX.
  - FIX: runs for 1 cycle, then goes to DONE.
  - DONE: on `out_valid & out_ready`, go to IDLE.
- On accept, the block latches operand magnitudes. When `SIGNED`=1 it also latches the two sign bits. It loads the partial remainder with 0 and the bit counter with `DIVIDEND_W`-1.
- Each CALC step (restoring):
  - shift {partial remainder, dividend} left by 1;
  - trial-subtract the divisor magnitude using `DIVISOR_W`+1 bits;
  - if the result is non-negative, keep it and shift a 1 into the quotient; otherwise shift in a 0.
- FIX applies sign correction and registers the outputs:
  - the quotient is negated if the operand signs differ (truncation toward zero);
  - the remainder is negated if the dividend was negative.
  - With `SIGNED`=0, FIX only registers the outputs.
- Signed overflow: most-negative dividend / -1 gives quotient = most-negative value (wraps), remainder 0, and no flag.
- Divide by zero: quotient = all ones, remainder = low `DIVISOR_W` bits of the dividend as latched, `div_by_zero`=1. This holds in both modes.
- Input and result transfers never overlap. Only one operation is in flight; `in_ready`=0 from the accept edge until the result is consumed.
- In DONE, `out_valid` stays high and `quotient`/`remainder`/`div_by_zero` hold stable until `out_ready` is sampled high.
- `div_by_zero` clears on the next accept.

## Timing
- Reset values: state IDLE, `out_valid`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0. `in_ready` reads 1 while in reset, but nothing is accepted while `sys_rst`=1.
- Latency, counted from the accept edge to the first edge at which `out_valid`=1:
  - normal division: `DIVIDEND_W`+1 cycles (26 at defaults);
  - zero divisor: 1 cycle.
- `out_valid` and all result outputs are registered. `in_ready` decodes directly from state (no combinational path from inputs).
- `in_valid`/`dividend`/`divisor` are ignored outside IDLE.
- `out_ready` has no effect while `out_valid`=0.
- Earliest next accept is the cycle after the result handshake, giving throughput of one result per `DIVIDEND_W`+3 cycles with `out_ready` tied high.
- Reset asserted mid-CALC, FIX or DONE:
  - the operation is aborted immediately (async), and every output returns to its reset value;
  - no result from the aborted operation is ever presented.

## Structure
- Package `divi_pkg`: the state enum (IDLE, CALC, FIX, DONE) and a counter-width function, clog2 of `DIVIDEND_W`.
- Sub-module `divi_step`: one combinational restoring step, taking the partial remainder, incoming dividend bit and divisor magnitude, and producing the next remainder and quotient bit. It is unit-testable on its own.
- The top level holds the FSM, counter, operand registers and sign fix.

## Test plan
All scenarios use default widths.
- Unsigned 120 / 10, `out_ready`=1 → `quotient`=12, `remainder`=0, `div_by_zero`=0; `out_valid` first seen 26 cycles after accept.
- Unsigned 33554431 / 65535 → `quotient`=512, `remainder`=511.
- `SIGNED`=1, check sign handling:
  - -7 / 2 → `quotient`=-3, `remainder`=-1;
  - 7 / -2 → `quotient`=-3, `remainder`=1;
  - most-negative / -1 → `quotient`=-16777216, `remainder`=0.
- Zero divisor: 100 / 0 → `out_valid` one cycle after accept, `quotient`=25'h1FFFFFF, `remainder`=100, `div_by_zero`=1. The next valid division clears the flag.
- Back-pressure: 120 / 10 with `out_ready` held low for 10 cycles in DONE:
  - outputs stay stable and `in_ready`=0 throughout;
  - a new `in_valid` pulse is ignored;
  - the result is released on the first `out_ready`=1.
- Reset at cycle 5 of CALC → all outputs go to 0 immediately. After release, 50 / 7 gives `quotient`=7, `remainder`=1 with normal latency.
